// File: rtl/shared_port_scheduler_pkg.sv
// rtl/shared_port_scheduler_pkg.sv - shared types and helpers for the shared port scheduler
package shared_port_scheduler_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } sched_state_e;

  localparam int TIMEOUT_CNT_WIDTH = 16;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/shared_port_scheduler_rotating_priority_select.sv
// rtl/shared_port_scheduler_rotating_priority_select.sv - combinational rotating-priority winner select
// Search starts just above the pointer, wraps to bit 0, and reaches the pointer position last.
module rotating_priority_select
  import shared_port_scheduler_pkg::*;
#(
  parameter int WORD_WIDTH  = 4,
  parameter int INDEX_WIDTH = clog2(WORD_WIDTH)
) (
  input  logic [WORD_WIDTH-1:0]  req_valid,
  input  logic [INDEX_WIDTH-1:0] pointer,
  output logic [WORD_WIDTH-1:0]  winner,
  output logic [INDEX_WIDTH-1:0] winner_index,
  output logic                   any_valid
);

  logic [WORD_WIDTH-1:0] upper;
  logic [WORD_WIDTH-1:0] search;

  always_comb begin
    upper = '0;
    for (int i = 0; i < WORD_WIDTH; i++) begin
      upper[i] = req_valid[i] && (i > int'(pointer));
    end
    // Nothing above the pointer: the lowest set bit of the full vector is the wrapped winner.
    search    = (|upper) ? upper : req_valid;
    any_valid = |req_valid;
    winner_index = '0;
    for (int i = WORD_WIDTH - 1; i >= 0; i--) begin
      if (search[i]) winner_index = INDEX_WIDTH'(i);
    end
    winner = any_valid ? (WORD_WIDTH'(1) << winner_index) : '0;
  end

endmodule

// File: rtl/shared_port_scheduler.sv
// rtl/shared_port_scheduler.sv - round-robin, transaction-locked owner of one shared port
// Optional stall timeout compiled in with SHARED_PORT_SCHEDULER_TIMEOUT_EN.
module shared_port_scheduler
  import shared_port_scheduler_pkg::*;
#(
  parameter  int WORD_WIDTH     = 4,
  parameter  int TIMEOUT_CYCLES = 16,
  localparam int INDEX_WIDTH    = clog2(WORD_WIDTH)
) (
  input  logic                   clock,
  input  logic                   clear,
  input  logic [WORD_WIDTH-1:0]  req_valid,
  input  logic [WORD_WIDTH-1:0]  req_last,
  output logic [WORD_WIDTH-1:0]  req_ready,
  input  logic                   port_ready,
  output logic                   port_valid,
  output logic [WORD_WIDTH-1:0]  grant,
  output logic [INDEX_WIDTH-1:0] grant_index,
  output logic                   busy,
  output logic                   timeout
);

  sched_state_e           state_q, state_d;
  logic [WORD_WIDTH-1:0]  grant_q, grant_d;
  logic [INDEX_WIDTH-1:0] grant_index_q, grant_index_d;
  logic [INDEX_WIDTH-1:0] pointer_q, pointer_d;
  logic                   busy_q, busy_d;

  logic [WORD_WIDTH-1:0]  winner;
  logic [INDEX_WIDTH-1:0] winner_index;
  logic                   any_valid;
  logic                   owner_valid;
  logic                   owner_last;
  logic                   transfer;
  logic                   expire;

  rotating_priority_select #(
    .WORD_WIDTH (WORD_WIDTH),
    .INDEX_WIDTH(INDEX_WIDTH)
  ) u_select (
    .req_valid   (req_valid),
    .pointer     (pointer_q),
    .winner      (winner),
    .winner_index(winner_index),
    .any_valid   (any_valid)
  );

  assign owner_valid = |(req_valid & grant_q);
  assign owner_last  = |(req_valid & req_last & grant_q);
  assign transfer    = (state_q == OWNED) && owner_valid && port_ready;

  assign port_valid  = (state_q == OWNED) && owner_valid;
  assign req_ready   = ((state_q == OWNED) && port_ready) ? grant_q : '0;
  assign grant       = grant_q;
  assign grant_index = grant_index_q;
  assign busy        = busy_q;

`ifdef SHARED_PORT_SCHEDULER_TIMEOUT_EN
  localparam logic [TIMEOUT_CNT_WIDTH-1:0] TIMEOUT_LIMIT = TIMEOUT_CNT_WIDTH'(TIMEOUT_CYCLES);

  logic [TIMEOUT_CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = '0;
    expire      = 1'b0;
    if ((state_q == OWNED) && !transfer) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
      expire      = (stall_cnt_d == TIMEOUT_LIMIT) && !clear;
    end
  end

  always_ff @(posedge clock) begin
    if (clear) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign timeout = expire;
`else
  localparam int UNUSED_TIMEOUT_CYCLES = TIMEOUT_CYCLES;

  assign expire  = 1'b0;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    grant_index_d = grant_index_q;
    pointer_d     = pointer_q;
    busy_d        = busy_q;
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          grant_d       = winner;
          grant_index_d = winner_index;
          pointer_d     = winner_index;
          state_d       = OWNED;
          busy_d        = 1'b1;
        end
      end
      OWNED: begin
        // A transfer on the expiry cycle suppresses expire, so only a last beat releases then.
        if ((transfer && owner_last) || expire) begin
          grant_d = '0;
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      grant_index_q <= '0;
      pointer_q     <= INDEX_WIDTH'(WORD_WIDTH - 1);
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      grant_index_q <= grant_index_d;
      pointer_q     <= pointer_d;
      busy_q        <= busy_d;
    end
  end

endmodule

// File: tb/tb_shared_port_scheduler.sv
// tb/tb_shared_port_scheduler.sv - scoreboard bench for shared_port_scheduler
module tb_shared_port_scheduler;

  logic       clock = 1'b0;
  logic       clear;
  logic [3:0] req_valid;
  logic [3:0] req_last;
  logic [3:0] req_ready;
  logic       port_ready;
  logic       port_valid;
  logic [3:0] grant;
  logic [1:0] grant_index;
  logic       busy;
  logic       timeout;

  int         n_compared   = 0;
  int         n_mismatched = 0;
  int         exp_q[$];
  logic [3:0] prev_grant;
  int         beats;

  always #5 clock = ~clock;

  shared_port_scheduler #(
    .WORD_WIDTH    (4),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clock      (clock),
    .clear      (clear),
    .req_valid  (req_valid),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .port_ready (port_ready),
    .port_valid (port_valid),
    .grant      (grant),
    .grant_index(grant_index),
    .busy       (busy),
    .timeout    (timeout)
  );

  // Observe the cycle the coming edge consumes, pop expected owner on each new grant.
  task automatic cycle();
    #1;
    if (grant !== 4'b0000 && prev_grant === 4'b0000) begin
      n_compared++;
      if (exp_q.size() == 0) begin
        n_mismatched++;
        $display("FAIL unexpected_grant: got grant=%b, expected no new grant", grant);
      end else begin
        int e;
        e = exp_q.pop_front();
        if (grant_index !== 2'(e) || grant !== (4'b0001 << e)) begin
          n_mismatched++;
          $display("FAIL grant_order: got grant=%b index=%0d, expected owner %0d", grant, grant_index, e);
        end
      end
    end
    n_compared++;
    if (!$onehot0(grant) || (req_ready & ~grant) !== 4'b0000 ||
        (busy && grant !== (4'b0001 << grant_index))) begin
      n_mismatched++;
      $display("FAIL invariant: got grant=%b index=%0d ready=%b busy=%b, expected one-hot grant matching index", grant, grant_index, req_ready, busy);
    end
    if (port_valid === 1'b1 && port_ready === 1'b1) beats++;
    prev_grant = grant;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic test_reset();
    clear = 1'b1; req_valid = '0; req_last = '0; port_ready = 1'b0;
    prev_grant = 4'bxxxx;
    @(posedge clock);
    @(negedge clock);
    cycle();
    n_compared++;
    if (grant !== 4'b0000 || grant_index !== 2'd0 || busy !== 1'b0 || timeout !== 1'b0) begin
      n_mismatched++;
      $display("FAIL reset_state: got grant=%b index=%0d busy=%b timeout=%b, expected all zero", grant, grant_index, busy, timeout);
    end
    n_compared++;
    if (port_valid !== 1'b0 || req_ready !== 4'b0000) begin
      n_mismatched++;
      $display("FAIL reset_outputs: got port_valid=%b req_ready=%b, expected 0/0000", port_valid, req_ready);
    end
    clear = 1'b0;
  endtask

  task automatic test_single();
    req_valid = 4'b0001; req_last = 4'b0001; port_ready = 1'b1;
    exp_q.push_back(0);
    beats = 0;
    #1;
    n_compared++;
    if (req_ready !== 4'b0000 || port_valid !== 1'b0) begin
      n_mismatched++;
      $display("FAIL idle_outputs: got req_ready=%b port_valid=%b, expected 0000/0", req_ready, port_valid);
    end
    cycle();
    #1;
    n_compared++;
    if (grant !== 4'b0001 || busy !== 1'b1 || port_valid !== 1'b1 || req_ready !== 4'b0001) begin
      n_mismatched++;
      $display("FAIL single_grant: got grant=%b busy=%b port_valid=%b req_ready=%b, expected 0001/1/1/0001", grant, busy, port_valid, req_ready);
    end
    cycle();
    req_valid = '0; req_last = '0;
    n_compared++;
    if (grant !== 4'b0000 || busy !== 1'b0) begin
      n_mismatched++;
      $display("FAIL single_release: got grant=%b busy=%b, expected 0000/0", grant, busy);
    end
    cycle();
    n_compared++;
    if (beats !== 1 || exp_q.size() !== 0) begin
      n_mismatched++;
      $display("FAIL single_beats: got %0d beats %0d pending, expected 1 beat 0 pending", beats, exp_q.size());
    end
  endtask

  task automatic test_round_robin();
    req_valid = 4'b1111; req_last = 4'b1111; port_ready = 1'b1;
    exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
    exp_q.push_back(0); exp_q.push_back(1);
    beats = 0;
    repeat (10) cycle();
    req_valid = '0; req_last = '0;
    cycle();
    n_compared++;
    if (beats !== 5 || exp_q.size() !== 0 || busy !== 1'b0) begin
      n_mismatched++;
      $display("FAIL round_robin: got %0d beats %0d pending busy=%b, expected 5 beats 0 pending busy=0", beats, exp_q.size(), busy);
    end
  endtask

  task automatic test_priority_example();
    req_valid = 4'b1011; req_last = 4'b1011; port_ready = 1'b1;
    exp_q.push_back(3);
    cycle();
    cycle();
    req_valid = '0; req_last = '0;
    cycle();
    n_compared++;
    if (exp_q.size() !== 0 || busy !== 1'b0) begin
      n_mismatched++;
      $display("FAIL priority_example: got %0d pending busy=%b, expected 0 pending busy=0", exp_q.size(), busy);
    end
  endtask

  task automatic test_lock();
    logic [3:0] rdy_pat;
    rdy_pat = 4'b1101;
    req_valid = 4'b0100; req_last = '0; port_ready = 1'b0;
    exp_q.push_back(2);
    cycle();
    beats = 0;
    for (int i = 0; i < 4; i++) begin
      req_valid  = 4'b0101;
      port_ready = rdy_pat[i];
      req_last   = (i == 3) ? 4'b0100 : 4'b0000;
      #1;
      n_compared++;
      if (req_ready[0] !== 1'b0 || grant !== 4'b0100) begin
        n_mismatched++;
        $display("FAIL lock_hold: step %0d got req_ready=%b grant=%b, expected ready[0]=0 grant=0100", i, req_ready, grant);
      end
      cycle();
    end
    n_compared++;
    if (beats !== 3) begin
      n_mismatched++;
      $display("FAIL lock_beats: got %0d beats, expected 3", beats);
    end
    exp_q.push_back(0);
    req_valid = 4'b0001; req_last = 4'b0001; port_ready = 1'b1;
    cycle();
    cycle();
    req_valid = '0; req_last = '0;
    cycle();
    n_compared++;
    if (exp_q.size() !== 0) begin
      n_mismatched++;
      $display("FAIL lock_handoff: got %0d pending, expected 0", exp_q.size());
    end
  endtask

  task automatic test_hold();
    req_valid = 4'b0010; req_last = '0; port_ready = 1'b1;
    exp_q.push_back(1);
    cycle();
    beats = 0;
    cycle();
    repeat (5) begin
      req_valid = 4'b1000;
      #1;
      n_compared++;
      if (grant !== 4'b0010 || port_valid !== 1'b0 || req_ready !== 4'b0010) begin
        n_mismatched++;
        $display("FAIL hold_gap: got grant=%b port_valid=%b req_ready=%b, expected 0010/0/0010", grant, port_valid, req_ready);
      end
      cycle();
    end
    req_valid = 4'b0010; req_last = 4'b0010;
    cycle();
    req_valid = '0; req_last = '0;
    #1;
    n_compared++;
    if (busy !== 1'b0 || beats !== 2 || exp_q.size() !== 0) begin
      n_mismatched++;
      $display("FAIL hold_complete: got busy=%b beats=%0d pending=%0d, expected 0/2/0", busy, beats, exp_q.size());
    end
    cycle();
  endtask

  task automatic test_clear_mid();
    req_valid = 4'b0010; req_last = '0; port_ready = 1'b1;
    exp_q.push_back(1);
    cycle();
    cycle();
    clear = 1'b1;
    cycle();
    #1;
    n_compared++;
    if (grant !== 4'b0000 || busy !== 1'b0 || port_valid !== 1'b0) begin
      n_mismatched++;
      $display("FAIL clear_mid: got grant=%b busy=%b port_valid=%b, expected 0000/0/0", grant, busy, port_valid);
    end
    clear = 1'b0;
    req_valid = 4'b1111; req_last = 4'b1111;
    exp_q.push_back(0);
    cycle();
    cycle();
    req_valid = '0; req_last = '0;
    cycle();
    n_compared++;
    if (exp_q.size() !== 0) begin
      n_mismatched++;
      $display("FAIL clear_restart: got %0d pending, expected 0", exp_q.size());
    end
  endtask

`ifdef SHARED_PORT_SCHEDULER_TIMEOUT_EN
  task automatic test_timeout();
    req_valid = 4'b0001; req_last = '0; port_ready = 1'b0;
    exp_q.push_back(0);
    cycle();
    for (int k = 1; k <= 4; k++) begin
      #1;
      n_compared++;
      if (timeout !== (k == 4)) begin
        n_mismatched++;
        $display("FAIL timeout_pulse: stall %0d got timeout=%b, expected %0d", k, timeout, (k == 4));
      end
      cycle();
    end
    n_compared++;
    if (grant !== 4'b0000 || busy !== 1'b0) begin
      n_mismatched++;
      $display("FAIL timeout_release: got grant=%b busy=%b, expected 0000/0", grant, busy);
    end
    exp_q.push_back(0);
    cycle();
    for (int k = 1; k <= 4; k++) begin
      port_ready = (k == 4);
      #1;
      n_compared++;
      if (timeout !== 1'b0) begin
        n_mismatched++;
        $display("FAIL timeout_transfer_wins: stall %0d got timeout=%b, expected 0", k, timeout);
      end
      cycle();
    end
    n_compared++;
    if (grant !== 4'b0001) begin
      n_mismatched++;
      $display("FAIL timeout_still_owned: got grant=%b, expected 0001", grant);
    end
    req_last = 4'b0001; port_ready = 1'b1;
    cycle();
    req_valid = '0; req_last = '0;
    cycle();
    n_compared++;
    if (exp_q.size() !== 0 || busy !== 1'b0) begin
      n_mismatched++;
      $display("FAIL timeout_end: got %0d pending busy=%b, expected 0/0", exp_q.size(), busy);
    end
  endtask
`else
  task automatic test_timeout();
    req_valid = 4'b0001; req_last = '0; port_ready = 1'b0;
    exp_q.push_back(0);
    cycle();
    repeat (20) begin
      #1;
      n_compared++;
      if (timeout !== 1'b0 || grant !== 4'b0001) begin
        n_mismatched++;
        $display("FAIL unbounded_lock: got timeout=%b grant=%b, expected 0/0001", timeout, grant);
      end
      cycle();
    end
    req_last = 4'b0001; port_ready = 1'b1;
    cycle();
    req_valid = '0; req_last = '0;
    cycle();
    n_compared++;
    if (exp_q.size() !== 0 || busy !== 1'b0) begin
      n_mismatched++;
      $display("FAIL unbounded_end: got %0d pending busy=%b, expected 0/0", exp_q.size(), busy);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_priority_example();
    test_lock();
    test_hold();
    test_clear_mid();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
